cmpgt_serial_ctrl: RTL and testbench

- Sequences a single shared 1-bit greater-than cell (o = a & ~b) to compare two WIDTH-bit unsigned operands, scanning MSB first.
- Each bit is evaluated twice. The forward pass presents (a_i, b_i) to detect GT. The reverse pass presents (b_i, a_i) to detect LT.
- The block has a valid/ready request port and a valid/ready result port.
- It sits between an operand source and the gate-level cmpgt cell used in fault-simulation benches, so every cell fault is exercised through a sequenced datapath.

---
 rtl/cmpgt_serial_ctrl_if.sv | 16 +
 rtl/cmpgt_serial_ctrl.sv | 94 +++++++++
 tb/tb_cmpgt_serial_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cmpgt_serial_ctrl_if.sv
// cmpgt_serial_ctrl_if: operand request and result handshake bundle for the serial comparator
interface cmpgt_serial_ctrl_if #(parameter int WIDTH = 8);
  localparam int SW = $clog2(2*WIDTH+1);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic gt;
  logic eq;
  logic lt;
  logic [SW-1:0] steps;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, gt, eq, lt, steps);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, gt, eq, lt, steps);
endinterface

// File: rtl/cmpgt_serial_ctrl.sv
// cmpgt_serial_ctrl: MSB-first magnitude compare by sequencing one shared 1-bit greater-than cell
module cmpgt_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter bit EARLY_EXIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  cmpgt_serial_ctrl_if.slave bus,
  output logic cell_a,
  output logic cell_b,
  input  logic cell_o
);
  localparam int SW = $clog2(2*WIDTH+1);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, FWD, REV, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic [SW-1:0] steps;
  logic decided, gt, eq, lt, hit, last;
  assign hit = cell_o && !decided;
  assign last = idx == '0;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.gt = gt;
  assign bus.eq = eq;
  assign bus.lt = lt;
  assign bus.steps = steps;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    cell_a = 1'b0;
    cell_b = 1'b0;
    case (state)
      IDLE: nxt = bus.in_valid ? FWD : IDLE;
      FWD: begin
        cell_a = a_r[idx];
        cell_b = b_r[idx];
        nxt = (hit && EARLY_EXIT) ? DONE : REV;
      end
      REV: begin
        cell_a = b_r[idx];
        cell_b = a_r[idx];
        nxt = ((hit && EARLY_EXIT) || last) ? DONE : FWD;
      end
      DONE: nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // once decided, later cell outputs never touch the result (constant-time mode keeps scanning)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      steps <= '0;
      decided <= 1'b0;
      gt <= 1'b0;
      eq <= 1'b0;
      lt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r <= bus.a;
          b_r <= bus.b;
          idx <= IW'(WIDTH-1);
          steps <= '0;
          decided <= 1'b0;
          gt <= 1'b0;
          eq <= 1'b0;
          lt <= 1'b0;
        end
        FWD: begin
          steps <= steps + SW'(1);
          if (hit) begin
            gt <= 1'b1;
            decided <= 1'b1;
          end
        end
        REV: begin
          steps <= steps + SW'(1);
          if (hit) begin
            lt <= 1'b1;
            decided <= 1'b1;
          end
          if (!last) idx <= idx - IW'(1);
          else if (!decided && !cell_o) eq <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cmpgt_serial_ctrl.sv
// tb_cmpgt_serial_ctrl: directed bench with a result scoreboard for early-exit and constant-time comparators
module tb_cmpgt_serial_ctrl;
  typedef struct {
    logic gt, eq, lt;
    int steps, dstep;
    logic [7:0] x, y;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0, stuck = 1'b0;
  logic iv = 1'b0, ordy = 1'b0;
  logic [7:0] ia = '0, ib = '0;
  logic ca1, cb1, ca0, cb0, co1, co0;
  int passed = 0, total = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  cmpgt_serial_ctrl_if #(.WIDTH(8)) i1 ();
  cmpgt_serial_ctrl_if #(.WIDTH(8)) i0 ();
  assign i1.in_valid = iv & ~sel;
  assign i0.in_valid = iv & sel;
  assign i1.a = ia;
  assign i1.b = ib;
  assign i0.a = ia;
  assign i0.b = ib;
  assign i1.out_ready = ordy & ~sel;
  assign i0.out_ready = ordy & sel;
  assign co1 = ca1 & ~cb1;
  assign co0 = (ca0 & ~cb0) | stuck;
  cmpgt_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1), .cell_a(ca1), .cell_b(cb1), .cell_o(co1));
  cmpgt_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0), .cell_a(ca0), .cell_b(cb0), .cell_o(co0));
  wire o_ir = sel ? i0.in_ready : i1.in_ready;
  wire o_ov = sel ? i0.out_valid : i1.out_valid;
  wire o_gt = sel ? i0.gt : i1.gt;
  wire o_eq = sel ? i0.eq : i1.eq;
  wire o_lt = sel ? i0.lt : i1.lt;
  wire [4:0] o_st = sel ? i0.steps : i1.steps;
  wire o_ca = sel ? ca0 : ca1;
  wire o_cb = sel ? cb0 : cb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input bit slow, input bit st);
    exp_t e;
    e.x = x; e.y = y; e.gt = 0; e.eq = 1; e.lt = 0; e.dstep = 1000;
    for (int k = 1; k <= 8; k++) begin
      if (st || (x[8-k] & ~y[8-k])) begin e.gt = 1; e.eq = 0; e.dstep = 2*k-1; break; end
      if (y[8-k] & ~x[8-k]) begin e.lt = 1; e.eq = 0; e.dstep = 2*k; break; end
    end
    e.steps = (!slow && !e.eq) ? e.dstep : 16;
    return e;
  endfunction

  task automatic issue(input logic [7:0] x, input logic [7:0] y, input bit s);
    sel = s;
    q.push_back(model(x, y, s, stuck));
    chk("in_ready_before_accept", o_ir, 1);
    iv = 1; ia = x; ib = y;
    @(negedge clk);
    iv = 0; ia = 8'($urandom); ib = 8'($urandom);
  endtask

  task automatic wait_result();
    exp_t e = q.pop_front();
    int c = 0;
    while (!o_ov && c <= 40) begin
      if (c < 16) chk("cell_trace", {o_ca, o_cb}, (c % 2 == 0) ? {e.x[7-c/2], e.y[7-c/2]} : {e.y[7-c/2], e.x[7-c/2]});
      chk("partial_result", {o_gt, o_eq, o_lt}, (c >= e.dstep) ? {e.gt, 1'b0, e.lt} : 3'b000);
      @(negedge clk);
      c++;
    end
    chk("out_valid", o_ov, 1);
    chk("gt", o_gt, e.gt);
    chk("eq", o_eq, e.eq);
    chk("lt", o_lt, e.lt);
    chk("steps", o_st, e.steps);
    chk("latency", c, e.steps);
  endtask

  task automatic handshake();
    ordy = 1;
    @(negedge clk);
    ordy = 0;
    chk("out_valid_after_hs", o_ov, 0);
    chk("in_ready_after_hs", o_ir, 1);
  endtask

  initial begin
    #3;
    chk("rst_out_valid", o_ov, 0);
    chk("rst_in_ready", o_ir, 1);
    chk("rst_result", {o_gt, o_eq, o_lt}, 0);
    chk("rst_steps", o_st, 0);
    chk("rst_cells", {o_ca, o_cb}, 0);
    @(negedge clk);
    rst_n = 1;
    issue(8'h80, 8'h7F, 0); wait_result(); handshake();
    issue(8'h3C, 8'h3D, 0); wait_result(); handshake();
    issue(8'hA5, 8'hA5, 0); wait_result(); handshake();
    issue(8'h80, 8'h00, 1); wait_result(); handshake();
    issue(8'h12, 8'h34, 1); wait_result(); handshake();
    stuck = 1;
    issue(8'h00, 8'hFF, 1); wait_result(); handshake();
    stuck = 0;
    issue(8'h80, 8'h7F, 0); wait_result();
    iv = 1; ia = 8'h01; ib = 8'h02;
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", o_ov, 1);
      chk("hold_in_ready", o_ir, 0);
      chk("hold_result", {o_gt, o_eq, o_lt, o_st}, {3'b100, 5'd1});
    end
    q.push_back(model(8'h01, 8'h02, 0, 0));
    ordy = 1;
    @(negedge clk);
    ordy = 0;
    chk("idle_after_hold", {o_ov, o_ir}, 2'b01);
    @(negedge clk);
    iv = 0;
    wait_result(); handshake();
    issue(8'h1F, 8'h1F, 0);
    repeat (6) @(negedge clk);
    chk("pre_reset_cells", {o_ca, o_cb}, 2'b11);
    chk("pre_reset_steps", o_st, 6);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", o_ov, 0);
    chk("midrst_in_ready", o_ir, 1);
    chk("midrst_result", {o_gt, o_eq, o_lt}, 0);
    chk("midrst_steps", o_st, 0);
    chk("midrst_cells", {o_ca, o_cb}, 0);
    rst_n = 1;
    q.delete();
    @(negedge clk);
    issue(8'hC3, 8'hC2, 0); wait_result(); handshake();
    for (int n = 0; n < 6; n++) begin
      issue(8'($urandom), 8'($urandom), n[0]); wait_result(); handshake();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
